usb_link_arbiter: RTL
=====================

# usb_link_arbiter

Shares the single half-duplex `usb_transceiver` between `NUM_EP` endpoint packet sources. Each endpoint presents a byte stream; the arbiter picks one round-robin, muxes its bytes onto the transceiver's `tx_data`/`tx_valid` interface and drives bus direction. It yields to host traffic whenever the receive side becomes active, and enforces an inter-packet gap after every packet in either direction.

## Interface
- `NUM_EP`, 4: number of requesting endpoints, 2..8.
- `IPG_CYCLES`, 16: idle clocks enforced after any RX EOP or TX completion; must be ≥1.
- `STALL_CYCLES`, 64: stall limit for a granted requester; used only with `USB_ARB_STALL_ABORT_EN`.
- `clk` in 1: the single clock.
- `nRST` in 1: reset, synchronous and active-high.
- `req_valid` in NUM_EP: endpoint i has a byte pending.
- `req_data` in 8*NUM_EP: byte of endpoint i at bits [8i+7:8i].
- `req_last` in NUM_EP: endpoint i's current byte ends its packet.
- `req_ready` out NUM_EP: byte of the granted endpoint consumed this cycle.
- `grant` out NUM_EP: one-hot current owner, or all-zero.
- `ep_abort` out NUM_EP: one-cycle pulse when the granted endpoint is aborted.
- `xcvr_tx_data` out 8: byte to the transceiver.
- `xcvr_tx_valid` out 1: byte valid to the transceiver.
- `xcvr_tx_ready` in 1: transceiver loads the offered byte this cycle.
- `xcvr_transmitting` in 1: transceiver TX path busy.
- `xcvr_rx_valid` in 1: receive-byte strobe from the transceiver.
- `xcvr_rx_eop` in 1: receive end-of-packet.
- `dir_tx` out 1: 1 = transmit owns the bus, 0 = receive (drives `tx_1_rx_0`).
- `rx_collision` out 1: one-cycle pulse when `xcvr_rx_valid` arrives while `dir_tx`=1.

## Operation
- FSM states: IDLE, RX, GAP, GRANT, SEND, DRAIN.
- IDLE:
  - `xcvr_rx_valid` → RX. RX wins over a simultaneous request.
  - Otherwise, any `req_valid` → GRANT. The winner is the first set bit searching upward from `rr_ptr`, wrapping modulo NUM_EP.
- RX: `dir_tx`=0, no grant. `xcvr_rx_eop` → GAP.
- GAP:
  - Gap counter loads IPG_CYCLES-1 on entry and decrements; at 0 → IDLE.
  - `xcvr_rx_valid` during GAP → RX; the gap restarts after that EOP.
- GRANT: registers `grant` one-hot and sets `dir_tx`=1; → SEND next cycle.
- SEND:
  - `xcvr_tx_valid` = `req_valid[g]`; `xcvr_tx_data` = `req_data[g]`; `req_ready[g]` = `xcvr_tx_ready & req_valid[g]`.
  - An accepted byte with `req_last[g]` → DRAIN.
- DRAIN: wait until `xcvr_transmitting`=0 → GAP.
  - On leaving DRAIN: `grant` clears, `dir_tx`=0, `rr_ptr` = (g+1) mod NUM_EP.
- Outside SEND, `xcvr_tx_valid`, `req_ready` and `xcvr_tx_data` are 0.
- In GRANT, SEND and DRAIN, `xcvr_rx_valid` is ignored apart from raising `rx_collision`.
- `rr_ptr` advances only on packet completion or abort, never in RX.

## Timing
- Reset values: state IDLE, `grant`=0, `dir_tx`=0, `rr_ptr`=0, gap counter 0, stall counter 0, `ep_abort`=0, `rx_collision`=0. A reset mid-packet drops the packet with no `ep_abort`.
- `grant`, `dir_tx`, `ep_abort` and `rx_collision` are registered.
- The `xcvr_tx_*` and `req_ready` paths are combinational from the requester inputs, gated by registered state.
- Request latency: `req_valid` high in IDLE at cycle t → `grant` and `dir_tx` at t+1 → first byte offered at t+2.
- Back-to-back packets from different endpoints are separated by at least DRAIN + IPG_CYCLES + 2 cycles.
- Lowering `req_valid` mid-packet stalls SEND. Without the macro there is no timeout.

## Configuration
- `USB_ARB_STALL_ABORT_EN` defined:
  - In SEND, a stall counter increments on every cycle with `req_valid[g]`=0 and clears on each accepted byte.
  - Reaching STALL_CYCLES pulses `ep_abort[g]` for one cycle and moves to DRAIN. Pointer and gap rules then apply as for normal completion.
- Undefined: no stall counter, `ep_abort` tied to 0, SEND waits indefinitely.

## Structure
- Package `usb_arb_pkg`: the FSM state enum, the `EP_MAX`=8 constant, and a `byte_t` typedef.
- Sub-module `rr_arbiter`: combinational round-robin pick. Inputs `req_valid` and `rr_ptr`; outputs a one-hot winner and an `any` flag.

## Test plan
- Endpoint 2 sends 3 bytes 0xC3, 0x11, 0x22 (last on 0x22), `xcvr_tx_ready` always 1:
  - `grant`=0100 at t+1; bytes appear at t+2..t+4.
  - DRAIN until `xcvr_transmitting` falls, then exactly 16 GAP cycles; `rr_ptr`=3.
- All four endpoints request continuously from reset → grants in order 0, 1, 2, 3, 0, each separated by the gap.
- `xcvr_rx_valid` and `req_valid[1]` rise in the same IDLE cycle → RX wins, no grant. After `xcvr_rx_eop`, 16 gap cycles, then endpoint 1 is granted.
- `xcvr_rx_valid` pulsed during SEND → `rx_collision` pulses for one cycle; the TX byte stream is unchanged.
- With `USB_ARB_STALL_ABORT_EN`, endpoint 0 drops `req_valid` after 1 byte for 64 cycles → `ep_abort`=0001 pulse, DRAIN, GAP, `rr_ptr`=1.
- Without the macro, the same stimulus holds SEND indefinitely, with `ep_abort` at 0 throughout.

Source files
------------

// File: rtl/usb_arb_pkg.sv
// Shared types for the USB link arbiter: FSM state encoding, endpoint limit, byte type.
package usb_arb_pkg;

    localparam int EP_MAX = 8;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RX    = 3'd1,
        ST_GAP   = 3'd2,
        ST_GRANT = 3'd3,
        ST_SEND  = 3'd4,
        ST_DRAIN = 3'd5
    } state_t;

endpackage

// File: rtl/usb_link_arbiter_rr.sv
// Combinational round-robin pick: first requester at or above rr_ptr, wrapping modulo NUM_EP.
module rr_arbiter
    import usb_arb_pkg::*;
#(
    parameter int NUM_EP = 4,
    parameter int IDX_W  = (NUM_EP > 1) ? $clog2(NUM_EP) : 1
) (
    input  logic [NUM_EP-1:0] req_valid,
    input  logic [IDX_W-1:0]  rr_ptr,
    output logic [NUM_EP-1:0] winner,
    output logic              any
);

    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        any    = 1'b0;
        for (int i = 0; i < NUM_EP; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_EP;
            if (!any && req_valid[idx]) begin
                winner[idx] = 1'b1;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/usb_link_arbiter.sv
// Round-robin arbiter sharing one half-duplex USB transceiver between NUM_EP packet sources.
// Optional stall timeout/abort is enabled by defining USB_ARB_STALL_ABORT_EN.
//   state | meaning
//   IDLE  | bus free, host RX has priority over endpoint requests
//   RX    | host traffic owns the bus until EOP
//   GAP   | inter-packet gap countdown
//   GRANT | owner registered, bus turned to TX
//   SEND  | owner's bytes muxed onto the transceiver
//   DRAIN | last byte handed off, waiting for the transceiver to go quiet
module usb_link_arbiter
    import usb_arb_pkg::*;
#(
    parameter int NUM_EP       = 4,
    parameter int IPG_CYCLES   = 16,
    parameter int STALL_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  nRST,
    input  logic [NUM_EP-1:0]     req_valid,
    input  logic [8*NUM_EP-1:0]   req_data,
    input  logic [NUM_EP-1:0]     req_last,
    output logic [NUM_EP-1:0]     req_ready,
    output logic [NUM_EP-1:0]     grant,
    output logic [NUM_EP-1:0]     ep_abort,
    output logic [7:0]            xcvr_tx_data,
    output logic                  xcvr_tx_valid,
    input  logic                  xcvr_tx_ready,
    input  logic                  xcvr_transmitting,
    input  logic                  xcvr_rx_valid,
    input  logic                  xcvr_rx_eop,
    output logic                  dir_tx,
    output logic                  rx_collision
);

    localparam int IDX_W = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;
    localparam int GAP_W = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(IPG_CYCLES - 1);

    state_t              state, state_nxt;
    logic [NUM_EP-1:0]   grant_nxt;
    logic                dir_nxt;
    logic [IDX_W-1:0]    rr_ptr, ptr_nxt, ptr_inc;
    logic [GAP_W-1:0]    gap_cnt, gap_nxt;
    logic [NUM_EP-1:0]   abort_nxt;
    logic [NUM_EP-1:0]   winner;
    logic                any_req;
    logic                g_valid, g_last, accept;
    byte_t               g_data;

    rr_arbiter #(.NUM_EP(NUM_EP), .IDX_W(IDX_W)) u_rr (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .winner    (winner),
        .any       (any_req)
    );

`ifdef USB_ARB_STALL_ABORT_EN
    localparam int STALL_W = $clog2(STALL_CYCLES + 1);
    logic [STALL_W-1:0] stall_cnt, stall_nxt;
`else
    logic unused_stall_cfg;
    assign unused_stall_cfg = (STALL_CYCLES > 0);
`endif

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        dir_nxt   = dir_tx;
        ptr_nxt   = rr_ptr;
        gap_nxt   = gap_cnt;
        abort_nxt = '0;
`ifdef USB_ARB_STALL_ABORT_EN
        stall_nxt = stall_cnt;
`endif
        g_valid       = 1'b0;
        g_last        = 1'b0;
        g_data        = '0;
        ptr_inc       = '0;
        accept        = 1'b0;
        xcvr_tx_valid = 1'b0;
        xcvr_tx_data  = '0;
        req_ready     = '0;

        for (int i = 0; i < NUM_EP; i++) begin
            if (grant[i]) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_data  = req_data[8*i +: 8];
                ptr_inc = IDX_W'((i + 1) % NUM_EP);
            end
        end

        case (state)
            ST_IDLE: begin
                if (xcvr_rx_valid) begin
                    state_nxt = ST_RX;
                end else if (any_req) begin
                    state_nxt = ST_GRANT;
                    grant_nxt = winner;
                    dir_nxt   = 1'b1;
                end
            end
            ST_RX: begin
                if (xcvr_rx_eop) begin
                    state_nxt = ST_GAP;
                    gap_nxt   = GAP_INIT;
                end
            end
            ST_GAP: begin
                if (xcvr_rx_valid) begin
                    state_nxt = ST_RX;
                end else if (gap_cnt == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    gap_nxt = gap_cnt - 1'b1;
                end
            end
            ST_GRANT: begin
                state_nxt = ST_SEND;
            end
            ST_SEND: begin
                accept        = xcvr_tx_ready & g_valid;
                xcvr_tx_valid = g_valid;
                xcvr_tx_data  = g_data;
                req_ready     = grant & {NUM_EP{accept}};
                if (accept && g_last) begin
                    state_nxt = ST_DRAIN;
                end
`ifdef USB_ARB_STALL_ABORT_EN
                if (accept) begin
                    stall_nxt = '0;
                end else if (!g_valid) begin
                    if (stall_cnt == STALL_W'(STALL_CYCLES - 1)) begin
                        state_nxt = ST_DRAIN;
                        abort_nxt = grant;
                        stall_nxt = '0;
                    end else begin
                        stall_nxt = stall_cnt + 1'b1;
                    end
                end
`endif
            end
            ST_DRAIN: begin
                if (!xcvr_transmitting) begin
                    state_nxt = ST_GAP;
                    gap_nxt   = GAP_INIT;
                    grant_nxt = '0;
                    dir_nxt   = 1'b0;
                    ptr_nxt   = ptr_inc;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = '0;
                dir_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (nRST) begin
            state        <= ST_IDLE;
            grant        <= '0;
            dir_tx       <= 1'b0;
            rr_ptr       <= '0;
            gap_cnt      <= '0;
            rx_collision <= 1'b0;
        end else begin
            state        <= state_nxt;
            grant        <= grant_nxt;
            dir_tx       <= dir_nxt;
            rr_ptr       <= ptr_nxt;
            gap_cnt      <= gap_nxt;
            rx_collision <= xcvr_rx_valid & dir_tx;
        end
    end

`ifdef USB_ARB_STALL_ABORT_EN
    always_ff @(posedge clk) begin
        if (nRST) begin
            stall_cnt <= '0;
            ep_abort  <= '0;
        end else begin
            stall_cnt <= stall_nxt;
            ep_abort  <= abort_nxt;
        end
    end
`else
    logic [NUM_EP-1:0] unused_abort;
    assign unused_abort = abort_nxt;
    assign ep_abort     = '0;
`endif

endmodule
